// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Opcode constants, counter encodings and saturating helpers
//                shared by the branch-resolution unit and its predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'(ST)) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'(SNT)) ? c : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_bht_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_bht_if
//  Description : Lookup port plus valid/ready operand slot and registered
//                outcome of the branch-resolution unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_bht_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lk_pc;
    logic            lk_taken;

    logic            in_valid;
    logic            in_ready;
    logic [5:0]      in_opcode;
    logic [4:0]      in_rt;
    logic [XLEN-1:0] in_rs_val;
    logic [XLEN-1:0] in_rt_val;
    logic [15:0]     in_offset;
    logic [XLEN-1:0] in_pc;
    logic            in_pred;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic            out_branch;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_mispred;
    logic [XLEN-1:0] out_redirect;

    modport master (
        output lk_pc,
        input  lk_taken,
        output in_valid, in_opcode, in_rt, in_rs_val, in_rt_val, in_offset,
               in_pc, in_pred, flush,
        input  in_ready,
        input  out_valid, out_branch, out_taken, out_target, out_mispred,
               out_redirect,
        output out_ready
    );

    modport slave (
        input  lk_pc,
        output lk_taken,
        input  in_valid, in_opcode, in_rt, in_rs_val, in_rt_val, in_offset,
               in_pc, in_pred, flush,
        output in_ready,
        output out_valid, out_branch, out_taken, out_target, out_mispred,
               out_redirect,
        input  out_ready
    );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_bht_bimodal_bht.sv
`default_nettype none
// ============================================================================
//  Module      : bimodal_bht
//  Description : Array of 2-bit saturating counters with one combinational
//                read port and one synchronous update port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bimodal_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_INIT = 1,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [IDX_W-1:0] ridx,
    output      logic             rd_taken,
    input  wire logic             we,
    input  wire logic [IDX_W-1:0] widx,
    input  wire logic             taken
);

    localparam logic [1:0] c_init = 2'(CTR_INIT);

    logic [1:0] r_ctr [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_init;
            end
        end else if (we) begin
            r_ctr[widx] <= taken ? sat_inc(r_ctr[widx]) : sat_dec(r_ctr[widx]);
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the old counter.
    assign rd_taken = r_ctr[ridx][1];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_bht
//  Description : Branch compare/decode, target adder and single-entry output
//                slot, with a bimodal predictor trained on resolved branches.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_bht
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_INIT    = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    branch_resolve_bht_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic            w_branch;
    logic            w_taken;
    logic            w_rs_neg;
    logic            w_rs_zero;
    logic            w_in_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_target;
    logic            w_unused_lk;

    logic            r_out_valid;
    logic            r_out_branch;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_target;
    logic            r_out_mispred;
    logic [XLEN-1:0] r_out_redirect;

    // Signed compares against zero reduce to sign bit and zero test.
    assign w_rs_neg  = bus.in_rs_val[XLEN-1];
    assign w_rs_zero = (bus.in_rs_val == '0);

    always_comb begin
        w_branch = 1'b0;
        w_taken  = 1'b0;
        case (bus.in_opcode)
            OP_REGIMM: begin
                if (bus.in_rt == RT_BLTZ) begin
                    w_branch = 1'b1;
                    w_taken  = w_rs_neg;
                end else if (bus.in_rt == RT_BGEZ) begin
                    w_branch = 1'b1;
                    w_taken  = !w_rs_neg;
                end
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_taken  = (bus.in_rs_val == bus.in_rt_val);
            end
            OP_BNE: begin
                w_branch = 1'b1;
                w_taken  = (bus.in_rs_val != bus.in_rt_val);
            end
            OP_BLEZ: begin
                w_branch = 1'b1;
                w_taken  = w_rs_neg || w_rs_zero;
            end
            OP_BGTZ: begin
                w_branch = 1'b1;
                w_taken  = !w_rs_neg && !w_rs_zero;
            end
            default: begin
                w_branch = 1'b0;
                w_taken  = 1'b0;
            end
        endcase
    end

    assign w_pc4    = bus.in_pc + XLEN'(4);
    assign w_sext   = XLEN'($signed(bus.in_offset));
    assign w_target = w_pc4 + (w_sext << 2);

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_branch   <= 1'b0;
            r_out_taken    <= 1'b0;
            r_out_target   <= '0;
            r_out_mispred  <= 1'b0;
            r_out_redirect <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_branch   <= w_branch;
            r_out_taken    <= w_taken;
            r_out_target   <= w_target;
            r_out_mispred  <= (w_taken != bus.in_pred);
            r_out_redirect <= w_taken ? w_target : w_pc4;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    bimodal_bht #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_INIT (CTR_INIT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .ridx     (bus.lk_pc[IDX_W+1:2]),
        .rd_taken (bus.lk_taken),
        .we       (w_accept && w_branch),
        .widx     (bus.in_pc[IDX_W+1:2]),
        .taken    (w_taken)
    );

    assign w_unused_lk = ^{bus.lk_pc[XLEN-1:IDX_W+2], bus.lk_pc[1:0]};

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_branch   = r_out_branch;
    assign bus.out_taken    = r_out_taken;
    assign bus.out_target   = r_out_target;
    assign bus.out_mispred  = r_out_mispred;
    assign bus.out_redirect = r_out_redirect;

endmodule
`default_nettype wire
